// File: rtl/pmux_sweep_checker.sv
// pmux_sweep_checker
//   Receiving and checking end of the $pmux cell test. It drives an exhaustive
//   A/B/S sweep into a parallel-mux DUT and samples the DUT's Y after a settle
//   window. Each sample is compared against an internal $pmux reference. The
//   block reports saturating error/skip counts and captures the first failing
//   vector.
//
//   Vector order: A outer (0..2^WIDTH-1), k middle (b = k*B_STEP mod 2^BW),
//   S inner (0..2^S_WIDTH-1). Each vector takes SETTLE+1 cycles.
//
//   Optional feature macro: PMUX_CHK_MULTIHOT_EN
//     defined   - multi-hot S is checked against the OR of the selected B slices
//     undefined - multi-hot S is not compared and counts into skip_cnt
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           begin a sweep (accepted only when idle or done)
//   a_o, b_o, s_o   stimulus to the DUT
//   y_i             DUT response
//   busy, done      sweep in progress / one-cycle end-of-sweep pulse
//   pass            last completed sweep had no mismatches
//   err_cnt         saturating mismatch count
//   skip_cnt        saturating count of vectors not compared
//   fail_valid      first-failure capture valid
//   fail_a/b/s/y    first failing vector and the Y observed for it
module pmux_sweep_checker #(
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned S_WIDTH = 3,
  parameter int unsigned B_STEP  = 19,
  parameter int unsigned B_STEPS = 4,
  parameter int unsigned SETTLE  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [WIDTH-1:0]           a_o,
  output logic [WIDTH*S_WIDTH-1:0]   b_o,
  output logic [S_WIDTH-1:0]         s_o,
  input  logic [WIDTH-1:0]           y_i,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [15:0]                err_cnt,
  output logic [15:0]                skip_cnt,
  output logic                       fail_valid,
  output logic [WIDTH-1:0]           fail_a,
  output logic [WIDTH*S_WIDTH-1:0]   fail_b,
  output logic [S_WIDTH-1:0]         fail_s,
  output logic [WIDTH-1:0]           fail_y
);

  localparam int unsigned BW = WIDTH * S_WIDTH;
  localparam int unsigned KW = (B_STEPS > 1) ? $clog2(B_STEPS) : 1;
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [BW-1:0] BInc  = BW'(B_STEP);
  localparam logic [KW-1:0] KLast = KW'(B_STEPS - 1);
  // Settle counter runs SETTLE-1 down to 0, giving SETTLE cycles in StSettle.
  localparam logic [CW-1:0] CLoad = CW'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [BW-1:0]    b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [S_WIDTH-1:0] s_q, s_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [15:0]      err_q, err_d;
  logic [15:0]      skip_q, skip_d;
  logic             fv_q, fv_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [BW-1:0]    fail_b_q, fail_b_d;
  logic [S_WIDTH-1:0] fail_s_q, fail_s_d;
  logic [WIDTH-1:0] fail_y_q, fail_y_d;

  logic [WIDTH-1:0] exp_y;
  logic             compare_en;
  logic             skip_en;
  logic             mismatch;
  logic             last_vec;

  // Reference $pmux: S==0 selects A, otherwise the OR of every selected slice
  // (identical to the slice itself when S is one-hot).
  always_comb begin
    exp_y = '0;
    for (int unsigned i = 0; i < S_WIDTH; i++) begin
      if (s_q[i]) exp_y = exp_y | b_q[i*WIDTH +: WIDTH];
    end
    if (s_q == '0) exp_y = a_q;
  end

`ifdef PMUX_CHK_MULTIHOT_EN
  assign compare_en = 1'b1;
  assign skip_en    = 1'b0;
`else
  logic multi_hot;
  assign multi_hot  = (s_q & (s_q - S_WIDTH'(1))) != '0;
  assign compare_en = !multi_hot;
  assign skip_en    = multi_hot;
`endif

  assign mismatch = compare_en && (y_i != exp_y);
  assign last_vec = (a_q == '1) && (k_q == KLast) && (s_q == '1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    s_d      = s_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    skip_d   = skip_q;
    fv_d     = fv_q;
    fail_a_d = fail_a_q;
    fail_b_d = fail_b_q;
    fail_s_d = fail_s_q;
    fail_y_d = fail_y_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          err_d   = '0;
          skip_d  = '0;
          fv_d    = 1'b0;
          pass_d  = 1'b0;
          a_d     = '0;
          b_d     = '0;
          k_d     = '0;
          s_d     = '0;
          busy_d  = 1'b1;
          cnt_d   = CLoad;
          state_d = StSettle;
        end else begin
          state_d = StIdle;
        end
      end
      StSettle: begin
        if (cnt_q == '0) state_d = StCheck;
        else             cnt_d   = cnt_q - CW'(1);
      end
      StCheck: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 16'd1;
          if (!fv_q) begin
            fv_d     = 1'b1;
            fail_a_d = a_q;
            fail_b_d = b_q;
            fail_s_d = s_q;
            fail_y_d = y_i;
          end
        end
        if (skip_en && (skip_q != '1)) skip_d = skip_q + 16'd1;

        if (last_vec) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          // S wraps every vector; k and A carry on S overflow.
          s_d = s_q + S_WIDTH'(1);
          if (s_q == '1) begin
            if (k_q == KLast) begin
              k_d = '0;
              b_d = '0;
              a_d = a_q + WIDTH'(1);
            end else begin
              k_d = k_q + KW'(1);
              b_d = b_q + BInc;
            end
          end
          cnt_d   = CLoad;
          state_d = StSettle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      s_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      skip_q   <= '0;
      fv_q     <= 1'b0;
      fail_a_q <= '0;
      fail_b_q <= '0;
      fail_s_q <= '0;
      fail_y_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      s_q      <= s_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      skip_q   <= skip_d;
      fv_q     <= fv_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
      fail_s_q <= fail_s_d;
      fail_y_q <= fail_y_d;
    end
  end

  assign a_o        = a_q;
  assign b_o        = b_q;
  assign s_o        = s_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign skip_cnt   = skip_q;
  assign fail_valid = fv_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign fail_s     = fail_s_q;
  assign fail_y     = fail_y_q;

endmodule

// File: tb/tb_pmux_sweep_checker.sv
// Bench for pmux_sweep_checker: a behavioural $pmux DUT (with selectable
// faults) sits between the checker's stimulus outputs and y_i. A second
// checker instance with SETTLE=3 covers the longer settle window.
module tb_pmux_sweep_checker;

`ifdef PMUX_CHK_MULTIHOT_EN
  localparam int SkipExp = 0;
  localparam int Y0Err   = 92;
`else
  localparam int SkipExp = 64;
  localparam int Y0Err   = 44;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic start3 = 1'b0;
  int   fault_mode = 0;  // 0 correct, 1 Y stuck at 0, 2 slices 1 and 2 swapped

  logic [1:0] a_o, y_i, fail_a, fail_y;
  logic [5:0] b_o, fail_b;
  logic [2:0] s_o, fail_s;
  logic busy, done, pass, fail_valid;
  logic [15:0] err_cnt, skip_cnt;

  logic [1:0] a3, y3, fa3, fy3;
  logic [5:0] b3, fb3;
  logic [2:0] s3, fs3;
  logic busy3, done3, pass3, fv3;
  logic [15:0] err3, skip3;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [1:0] pmux_model(input logic [1:0] a, input logic [5:0] b,
                                            input logic [2:0] s, input int mode);
    logic [1:0] y;
    int j;
    y = 2'b00;
    if (s == 3'b000) y = a;
    else begin
      for (int i = 0; i < 3; i++) begin
        j = i;
        if (mode == 2 && i == 1) j = 2;
        if (mode == 2 && i == 2) j = 1;
        if (s[i]) y = y | b[j*2 +: 2];
      end
    end
    if (mode == 1) y = 2'b00;
    return y;
  endfunction

  assign y_i = pmux_model(a_o, b_o, s_o, fault_mode);
  assign y3  = pmux_model(a3, b3, s3, fault_mode);

  pmux_sweep_checker u_dut (
    .clk(clk), .rst(rst), .start(start),
    .a_o(a_o), .b_o(b_o), .s_o(s_o), .y_i(y_i),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .skip_cnt(skip_cnt), .fail_valid(fail_valid),
    .fail_a(fail_a), .fail_b(fail_b), .fail_s(fail_s), .fail_y(fail_y)
  );

  pmux_sweep_checker #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .a_o(a3), .b_o(b3), .s_o(s3), .y_i(y3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .skip_cnt(skip3), .fail_valid(fv3),
    .fail_a(fa3), .fail_b(fb3), .fail_s(fs3), .fail_y(fy3)
  );

  // Counts edges after the start edge until done is seen; -1 on timeout.
  task automatic wait_done(input bit use3, input int limit, output int edges);
    edges = -1;
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk); #1;
      if ((use3 ? done3 : done) === 1'b1) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, pass, fail_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, done, pass, fail_valid});
    end
    n_checks++;
    if ({err_cnt, skip_cnt} !== 32'd0) begin
      n_fail++; $display("FAIL reset_counts: got err=%0d skip=%0d want 0/0", err_cnt, skip_cnt);
    end
    n_checks++;
    if ({a_o, b_o, s_o, fail_a, fail_b, fail_s, fail_y} !== 24'd0) begin
      n_fail++; $display("FAIL reset_vectors: got a=%0d b=%0d s=%0d fa=%0d fb=%0d fs=%0d fy=%0d want 0",
                         a_o, b_o, s_o, fail_a, fail_b, fail_s, fail_y);
    end
  endtask

  task automatic test_correct_sweep();
    int e;
    fault_mode = 0;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL correct_busy: got busy=%b done=%b want 1/0", busy, done);
    end
    wait_done(1'b0, 600, e);
    n_checks++;
    if (e !== 256) begin
      n_fail++; $display("FAIL correct_done_edge: got %0d want 256", e);
    end
    n_checks++;
    if (err_cnt !== 16'd0 || skip_cnt !== 16'(SkipExp)) begin
      n_fail++; $display("FAIL correct_counts: got err=%0d skip=%0d want 0/%0d",
                         err_cnt, skip_cnt, SkipExp);
    end
    n_checks++;
    if (pass !== 1'b1 || fail_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL correct_status: got pass=%b fv=%b busy=%b want 1/0/0",
                         pass, fail_valid, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || pass !== 1'b1) begin
      n_fail++; $display("FAIL correct_done_pulse: got done=%b pass=%b want 0/1", done, pass);
    end
  endtask

  task automatic test_y_zero();
    int e;
    fault_mode = 1;
    pulse_start();
    wait_done(1'b0, 600, e);
    n_checks++;
    if (e !== 256) begin
      n_fail++; $display("FAIL yzero_done_edge: got %0d want 256", e);
    end
    n_checks++;
    if (err_cnt !== 16'(Y0Err) || skip_cnt !== 16'(SkipExp)) begin
      n_fail++; $display("FAIL yzero_counts: got err=%0d skip=%0d want %0d/%0d",
                         err_cnt, skip_cnt, Y0Err, SkipExp);
    end
    // First nonzero expectation: A=0, b=19 (slices 3,0,1), S=1 -> 3.
    n_checks++;
    if ({fail_valid, fail_a, fail_b, fail_s, fail_y} !== {1'b1, 2'd0, 6'd19, 3'd1, 2'd0}) begin
      n_fail++; $display("FAIL yzero_capture: got fv=%b a=%0d b=%0d s=%0d y=%0d want 1/0/19/1/0",
                         fail_valid, fail_a, fail_b, fail_s, fail_y);
    end
    n_checks++;
    if (pass !== 1'b0) begin
      n_fail++; $display("FAIL yzero_pass: got %b want 0", pass);
    end
  endtask

  task automatic test_swap();
    int e;
    fault_mode = 2;
    pulse_start();
    n_checks++;
    if (fail_valid !== 1'b0 || pass !== 1'b0 || err_cnt !== 16'd0) begin
      n_fail++; $display("FAIL swap_cleared: got fv=%b pass=%b err=%0d want 0/0/0",
                         fail_valid, pass, err_cnt);
    end
    wait_done(1'b0, 600, e);
    // A=0, b=19, S=2 expects slice1=0 but the swapped DUT returns slice2=1.
    n_checks++;
    if ({fail_valid, fail_a, fail_b, fail_s, fail_y} !== {1'b1, 2'd0, 6'd19, 3'd2, 2'd1}) begin
      n_fail++; $display("FAIL swap_capture: got fv=%b a=%0d b=%0d s=%0d y=%0d want 1/0/19/2/1",
                         fail_valid, fail_a, fail_b, fail_s, fail_y);
    end
    n_checks++;
    if (pass !== 1'b0 || skip_cnt !== 16'(SkipExp)) begin
      n_fail++; $display("FAIL swap_status: got pass=%b skip=%0d want 0/%0d",
                         pass, skip_cnt, SkipExp);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    bit seen;
    fault_mode = 1;
    pulse_start();
    repeat (99) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, pass, fail_valid, err_cnt, skip_cnt, a_o, b_o, s_o,
         fail_a, fail_b, fail_s, fail_y} !== 60'd0) begin
      n_fail++; $display("FAIL midrst_zero: got busy=%b err=%0d skip=%0d fv=%b a=%0d b=%0d s=%0d want 0",
                         busy, err_cnt, skip_cnt, fail_valid, a_o, b_o, s_o);
    end
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL midrst_no_resume: got activity=%b want 0", seen);
    end
    fault_mode = 0;
    pulse_start();
    wait_done(1'b0, 600, e);
    n_checks++;
    if (e !== 256 || pass !== 1'b1) begin
      n_fail++; $display("FAIL midrst_restart: got edge=%0d pass=%b want 256/1", e, pass);
    end
  endtask

  task automatic test_start_held();
    int e;
    fault_mode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    wait_done(1'b0, 600, e);
    n_checks++;
    if (e !== 256 || err_cnt !== 16'(Y0Err)) begin
      n_fail++; $display("FAIL held_first: got edge=%0d err=%0d want 256/%0d", e, err_cnt, Y0Err);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, pass, fail_valid} !== 4'b1000 || err_cnt !== 16'd0 ||
        {a_o, b_o, s_o} !== 11'd0) begin
      n_fail++; $display("FAIL held_restart: got busy=%b done=%b pass=%b fv=%b err=%0d a=%0d b=%0d s=%0d want 1/0/0/0/0/0/0/0",
                         busy, done, pass, fail_valid, err_cnt, a_o, b_o, s_o);
    end
    wait_done(1'b0, 600, e);
    n_checks++;
    if (e !== 256) begin
      n_fail++; $display("FAIL held_second: got %0d want 256", e);
    end
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err_cnt !== 16'(Y0Err)) begin
      n_fail++; $display("FAIL held_idle: got busy=%b done=%b err=%0d want 0/0/%0d",
                         busy, done, err_cnt, Y0Err);
    end
  endtask

  task automatic test_settle3();
    int e;
    fault_mode = 0;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    wait_done(1'b1, 1200, e);
    n_checks++;
    if (e !== 512) begin
      n_fail++; $display("FAIL settle3_done_edge: got %0d want 512", e);
    end
    n_checks++;
    if (pass3 !== 1'b1 || err3 !== 16'd0 || skip3 !== 16'(SkipExp)) begin
      n_fail++; $display("FAIL settle3_status: got pass=%b err=%0d skip=%0d want 1/0/%0d",
                         pass3, err3, skip3, SkipExp);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_correct_sweep();
    test_y_zero();
    test_swap();
    test_reset_mid();
    test_start_held();
    test_settle3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
